// File: rtl/uart_program_loader.sv
// 8N1 UART receiver that streams bytes into CPU program memory from address 0,
// holding the CPU in reset until DEPTH bytes have been written.
module uart_program_loader #(
  parameter int Baudrate = 24,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Load,
  input  logic              RX,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [7:0]        Mem_wdata,
  output logic              Cpu_hold,
  output logic              Done,
  output logic              FE,
  output logic [ADDR_W:0]   Byte_count
);

  localparam int CntW = (Baudrate > 1) ? $clog2(Baudrate) : 1;
  localparam logic [CntW-1:0]   HalfLast  = CntW'(Baudrate / 2 - 1);
  localparam logic [CntW-1:0]   BitLast   = CntW'(Baudrate - 1);
  localparam logic [ADDR_W:0]   LastCount = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxState_e;
  typedef enum logic [1:0] {L_IDLE, L_LOAD, L_DONE} ldState_e;

  logic            rxSync1_q, rxSync2_q;
  rxState_e        rxState_q, rxState_d;
  logic [CntW-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            stopErr_q, stopErr_d;
  logic            byteValid, frameErr;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rxSync1_q <= 1'b1;
      rxSync2_q <= 1'b1;
      rxState_q <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      stopErr_q <= 1'b0;
    end else begin
      rxSync1_q <= RX;
      rxSync2_q <= rxSync1_q;
      rxState_q <= rxState_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      stopErr_q <= stopErr_d;
    end
  end

  // stopErr_q marks a broken stop bit: wait for the line to return high before re-arming.
  always_comb begin
    rxState_d = rxState_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    stopErr_d = stopErr_q;
    byteValid = 1'b0;
    frameErr  = 1'b0;
    case (rxState_q)
      IDLE: begin
        if (!rxSync2_q) begin
          rxState_d = START;
          baudCnt_d = '0;
          bitCnt_d  = '0;
        end
      end
      START: begin
        if (baudCnt_q == HalfLast) begin
          baudCnt_d = '0;
          rxState_d = rxSync2_q ? IDLE : DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baudCnt_q == BitLast) begin
          baudCnt_d = '0;
          shift_d   = {rxSync2_q, shift_q[7:1]};
          bitCnt_d  = bitCnt_q + 3'd1;
          if (bitCnt_q == 3'd7) rxState_d = STOP;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      STOP: begin
        if (stopErr_q) begin
          if (rxSync2_q) begin
            rxState_d = IDLE;
            stopErr_d = 1'b0;
          end
        end else if (baudCnt_q == BitLast) begin
          baudCnt_d = '0;
          if (rxSync2_q) begin
            byteValid = 1'b1;
            rxState_d = IDLE;
          end else begin
            frameErr  = 1'b1;
            stopErr_d = 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      default: rxState_d = IDLE;
    endcase
  end

  logic              loadPrev_q, loadEdge;
  ldState_e          ldState_q, ldState_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              we_q, we_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              fe_q, fe_d;

  assign loadEdge = Load & ~loadPrev_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      loadPrev_q <= 1'b0;
      ldState_q  <= L_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      loadPrev_q <= Load;
      ldState_q  <= ldState_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      fe_q       <= fe_d;
    end
  end

  // Address/count advance in the strobe cycle so Mem_addr is stable during the write;
  // the final write parks the address at DEPTH-1 instead of wrapping.
  always_comb begin
    ldState_d = ldState_q;
    addr_d    = addr_q;
    count_d   = count_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    hold_d    = hold_q;
    done_d    = done_q;
    fe_d      = loadEdge ? frameErr : (fe_q | frameErr);
    if (loadEdge) begin
      ldState_d = L_LOAD;
      addr_d    = '0;
      count_d   = '0;
      hold_d    = 1'b1;
      done_d    = 1'b0;
    end else if (we_q) begin
      count_d = count_q + 1'b1;
      if (count_q == LastCount) begin
        ldState_d = L_DONE;
        hold_d    = 1'b0;
        done_d    = 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end else if (ldState_q == L_LOAD && byteValid) begin
      we_d    = 1'b1;
      wdata_d = shift_q;
    end
  end

  assign Mem_we     = we_q;
  assign Mem_addr   = addr_q;
  assign Mem_wdata  = wdata_q;
  assign Cpu_hold   = hold_q;
  assign Done       = done_q;
  assign FE         = fe_q;
  assign Byte_count = count_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomised UART frames checked against a queue-based model of the expected
// program-memory writes and loader status.
module tb_uart_program_loader;

  localparam int Baud  = 24;
  localparam int AW    = 5;
  localparam int Depth = 32;

  logic          Clk = 1'b0;
  logic          Reset, Load, RX;
  logic          Mem_we, Cpu_hold, Done, FE;
  logic [AW-1:0] Mem_addr;
  logic [7:0]    Mem_wdata;
  logic [AW:0]   Byte_count;

  uart_program_loader #(.Baudrate(Baud), .ADDR_W(AW), .DEPTH(Depth)) dut (
    .Clk(Clk), .Reset(Reset), .Load(Load), .RX(RX),
    .Mem_we(Mem_we), .Mem_addr(Mem_addr), .Mem_wdata(Mem_wdata),
    .Cpu_hold(Cpu_hold), .Done(Done), .FE(FE), .Byte_count(Byte_count)
  );

  always #2 Clk = ~Clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    bit            last;
  } wr_t;

  wr_t           expQ[$];
  wr_t           curExp;
  int            checks = 0;
  int            errors = 0;
  bit            modelLoading = 0, modelDone = 0, modelFe = 0;
  int            modelCount = 0;
  int            writesSeen = 0;
  int            wBefore;
  logic [7:0]    lastData = '0;
  logic [AW-1:0] lastAddr = '0;
  bit            finalPending = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Every write strobe must match the next queued expectation; the cycle after
  // the final write must show the session completed.
  always @(negedge Clk) begin
    if (Reset) begin
      finalPending = 0;
    end else begin
      if (finalPending) begin
        checkOutput("done_after_last", 32'(Done), 32'd1);
        checkOutput("hold_after_last", 32'(Cpu_hold), 32'd0);
        checkOutput("count_after_last", 32'(Byte_count), 32'(Depth));
        finalPending = 0;
      end
      if (Mem_we) begin
        writesSeen++;
        lastData = Mem_wdata;
        lastAddr = Mem_addr;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write actual addr=%0d data=%0h required no write at %0t",
                   Mem_addr, Mem_wdata, $time);
        end else begin
          curExp = expQ.pop_front();
          checkOutput("write_addr", 32'(Mem_addr), 32'(curExp.addr));
          checkOutput("write_data", 32'(Mem_wdata), 32'(curExp.data));
          checkOutput("write_count", 32'(Byte_count), 32'(curExp.addr));
          checkOutput("write_hold", 32'(Cpu_hold), 32'd1);
          finalPending = curExp.last;
        end
      end
    end
  end

  task automatic checkState(input string tag);
    checkOutput({tag, "_pending"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_hold"}, 32'(Cpu_hold), 32'(modelLoading));
    checkOutput({tag, "_done"}, 32'(Done), 32'(modelDone));
    checkOutput({tag, "_fe"}, 32'(FE), 32'(modelFe));
    checkOutput({tag, "_count"}, 32'(Byte_count), 32'(modelCount));
  endtask

  task automatic doReset();
    @(negedge Clk);
    Reset = 1'b1;
    RX    = 1'b1;
    waitCycles(3);
    Reset = 1'b0;
    modelLoading = 0;
    modelDone    = 0;
    modelFe      = 0;
    modelCount   = 0;
    expQ.delete();
  endtask

  task automatic pulseLoad();
    @(negedge Clk);
    Load = 1'b1;
    waitCycles(2);
    Load = 1'b0;
    modelLoading = 1;
    modelDone    = 0;
    modelFe      = 0;
    modelCount   = 0;
  endtask

  task automatic glitch(input int lowCycles);
    @(negedge Clk);
    RX = 1'b0;
    waitCycles(lowCycles);
    RX = 1'b1;
    waitCycles(Baud);
  endtask

  // Sends one 8N1 frame and records what the loader must do with it.
  task automatic applyStimulus(input logic [7:0] data, input bit goodStop);
    if (goodStop && modelLoading) begin
      expQ.push_back('{addr: AW'(modelCount), data: data, last: (modelCount == Depth - 1)});
      modelCount++;
      if (modelCount == Depth) begin
        modelLoading = 0;
        modelDone    = 1;
      end
    end
    if (!goodStop) modelFe = 1;
    @(negedge Clk);
    RX = 1'b0;
    waitCycles(Baud);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      waitCycles(Baud);
    end
    RX = goodStop;
    waitCycles(Baud);
    RX = 1'b1;
    waitCycles(Baud * (1 + int'($urandom_range(0, 2))));
  endtask

  initial begin
    Reset = 1'b1;
    Load  = 1'b0;
    RX    = 1'b1;
    waitCycles(3);
    checkOutput("reset_we", 32'(Mem_we), 32'd0);
    checkOutput("reset_addr", 32'(Mem_addr), 32'd0);
    checkOutput("reset_wdata", 32'(Mem_wdata), 32'd0);
    checkOutput("reset_hold", 32'(Cpu_hold), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    checkOutput("reset_fe", 32'(FE), 32'd0);
    checkOutput("reset_count", 32'(Byte_count), 32'd0);
    Reset = 1'b0;
    waitCycles(1000);
    checkOutput("idle_no_writes", 32'(writesSeen), 32'd0);

    pulseLoad();
    checkOutput("load_hold", 32'(Cpu_hold), 32'd1);
    applyStimulus(8'hA5, 1'b1);
    checkState("single");
    checkOutput("single_writes", 32'(writesSeen), 32'd1);
    checkOutput("single_addr", 32'(lastAddr), 32'd0);
    checkOutput("single_data", 32'(lastData), 32'hA5);
    checkOutput("single_count", 32'(Byte_count), 32'd1);
    checkOutput("single_done", 32'(Done), 32'd0);

    pulseLoad();
    for (int i = 0; i < Depth; i++) applyStimulus(8'(i), 1'b1);
    checkState("full");
    checkOutput("full_done", 32'(Done), 32'd1);
    checkOutput("full_hold", 32'(Cpu_hold), 32'd0);
    checkOutput("full_count", 32'(Byte_count), 32'd32);
    checkOutput("full_addr", 32'(Mem_addr), 32'd31);
    checkOutput("full_last_data", 32'(lastData), 32'h1F);
    wBefore = writesSeen;
    applyStimulus(8'hC3, 1'b1);
    checkOutput("extra_byte_no_write", 32'(writesSeen), 32'(wBefore));

    pulseLoad();
    wBefore = writesSeen;
    applyStimulus(8'h3C, 1'b0);
    checkState("frame_err");
    checkOutput("frame_err_fe", 32'(FE), 32'd1);
    checkOutput("frame_err_no_write", 32'(writesSeen), 32'(wBefore));
    applyStimulus(8'h5A, 1'b1);
    checkState("after_err");
    checkOutput("after_err_addr", 32'(lastAddr), 32'd0);
    checkOutput("after_err_data", 32'(lastData), 32'h5A);
    checkOutput("after_err_fe", 32'(FE), 32'd1);
    pulseLoad();
    waitCycles(2);
    checkOutput("fe_cleared_by_load", 32'(FE), 32'd0);

    wBefore = writesSeen;
    glitch(8);
    checkState("glitch");
    checkOutput("glitch_no_write", 32'(writesSeen), 32'(wBefore));
    checkOutput("glitch_fe", 32'(FE), 32'd0);
    doReset();
    applyStimulus(8'h77, 1'b1);
    checkOutput("no_load_no_write", 32'(writesSeen), 32'(wBefore));

    pulseLoad();
    applyStimulus(8'h22, 1'b1);
    @(negedge Clk);
    RX = 1'b0;
    waitCycles(Baud);
    for (int i = 0; i < 3; i++) begin
      RX = (i == 1);
      waitCycles(Baud);
    end
    doReset();
    checkOutput("midbyte_we", 32'(Mem_we), 32'd0);
    checkOutput("midbyte_addr", 32'(Mem_addr), 32'd0);
    checkOutput("midbyte_hold", 32'(Cpu_hold), 32'd0);
    checkOutput("midbyte_count", 32'(Byte_count), 32'd0);
    waitCycles(12 * Baud);
    checkState("midbyte");
    pulseLoad();
    applyStimulus(8'h11, 1'b1);
    checkOutput("reload_addr", 32'(lastAddr), 32'd0);
    checkOutput("reload_data", 32'(lastData), 32'h11);

    for (int s = 0; s < 3; s++) begin
      int n;
      int r;
      pulseLoad();
      n = int'($urandom_range(5, 36));
      for (int k = 0; k < n; k++) begin
        r = int'($urandom_range(0, 15));
        if (r == 0) pulseLoad();
        else if (r == 1) glitch(int'($urandom_range(2, 9)));
        applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0));
      end
      checkState("random");
    end

    waitCycles(10);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
